// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the multicycle CPU PC and
//               exception logic (cause codes, exception FSM states, vector
//               byte addresses, EPC adjustment).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Exception cause codes as seen on exc_cause
  typedef enum logic [1:0] {
    EXC_NONE   = 2'd0,
    EXC_OPCODE = 2'd1,
    EXC_OVF    = 2'd2,
    EXC_DIV0   = 2'd3
  } exc_cause_e;

  // Exception entry sequence states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_LOAD = 2'd3
  } exc_state_e;

  // Byte addresses of the handler vectors
  localparam logic [31:0] VEC_OPCODE_ADDR = 32'd253;
  localparam logic [31:0] VEC_OVF_ADDR    = 32'd254;
  localparam logic [31:0] VEC_DIV0_ADDR   = 32'd255;

  // PC is already incremented at fetch, so EPC backs off by one word
  localparam logic [31:0] EPC_OFFSET_DEFAULT = 32'd4;

  // Width of the memory latency counter (latency range 1..7)
  localparam int LAT_CNT_W = 3;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/exc_priority_enc.sv
`default_nettype none
// ============================================================================
// Module      : exc_priority_enc
// Description : Combinational priority encoder for the three exception
//               sources. Priority is opcode > overflow > div0. Produces the
//               cause code and the matching handler-vector byte address.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_priority_enc
  import cpu_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_ADDR,
  parameter logic [31:0] VEC_OVF    = VEC_OVF_ADDR,
  parameter logic [31:0] VEC_DIV0   = VEC_DIV0_ADDR
) (
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  output logic        exc_any,
  output exc_cause_e  cause,
  output logic [31:0] vec_addr
);

  // Select the highest-priority active cause and its vector address
  always_comb begin
    exc_any  = exc_opcode | exc_overflow | exc_div0;
    cause    = EXC_NONE;
    vec_addr = '0;
    if (exc_opcode) begin
      cause    = EXC_OPCODE;
      vec_addr = VEC_OPCODE;
    end else if (exc_overflow) begin
      cause    = EXC_OVF;
      vec_addr = VEC_OVF;
    end else if (exc_div0) begin
      cause    = EXC_DIV0;
      vec_addr = VEC_DIV0;
    end
  end

endmodule : exc_priority_enc
`default_nettype wire

// File: rtl/pc_exception_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_exception_unit
// Description : Program counter and EPC registers of the multicycle CPU.
//               Writes the selected next-PC under control-unit enables and
//               runs the exception entry sequence: save EPC, fetch the
//               handler-vector byte after a fixed memory latency, then load
//               the zero-extended vector into the PC.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_exception_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,   // request-to-data latency, 1..7
  parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_ADDR,
  parameter logic [31:0] VEC_OVF    = VEC_OVF_ADDR,
  parameter logic [31:0] VEC_DIV0   = VEC_DIV0_ADDR,
  parameter logic [31:0] EPC_OFFSET = EPC_OFFSET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        branch_cond,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic [31:0] vector_out,
  output logic [31:0] exc_mem_addr,
  output logic        exc_mem_req,
  output logic        exc_busy,
  output logic [1:0]  exc_cause
);

  // Counter preload: the data arrives MEM_LAT cycles after the request
  // cycle, and WAIT itself consumes one of those cycles per count value.
  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT - 1);

  exc_state_e           state;
  exc_state_e           state_next;
  logic [LAT_CNT_W-1:0] lat_cnt;
  exc_cause_e           cause_q;

  logic        exc_any;
  exc_cause_e  enc_cause;
  logic [31:0] enc_addr;

  logic take_exc;
  logic pc_en;
  logic capture;
  logic load_vec;

  // Only the low byte of the memory word carries the vector
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^mem_rdata[31:8];

  exc_priority_enc #(
    .VEC_OPCODE (VEC_OPCODE),
    .VEC_OVF    (VEC_OVF),
    .VEC_DIV0   (VEC_DIV0)
  ) u_prio (
    .exc_opcode   (exc_opcode),
    .exc_overflow (exc_overflow),
    .exc_div0     (exc_div0),
    .exc_any      (exc_any),
    .cause        (enc_cause),
    .vec_addr     (enc_addr)
  );

  assign exc_cause = cause_q;

  // Exception FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode; enables and exceptions only act in IDLE
  always_comb begin
    state_next  = state;
    exc_busy    = 1'b1;
    exc_mem_req = 1'b0;
    take_exc    = 1'b0;
    pc_en       = 1'b0;
    capture     = 1'b0;
    load_vec    = 1'b0;
    case (state)
      ST_IDLE: begin
        exc_busy = 1'b0;
        if (exc_any) begin
          take_exc   = 1'b1;
          state_next = ST_REQ;
        end else begin
          pc_en = pc_write | (pc_write_cond & branch_cond);
        end
      end
      ST_REQ: begin
        exc_mem_req = 1'b1;
        state_next  = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt == '0) begin
          capture    = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_vec   = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Memory latency counter: preloaded in REQ, counts down through WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (state == ST_REQ) begin
      lat_cnt <= LAT_INIT;
    end else if (state == ST_WAIT && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // PC, EPC, cause, vector and vector-address registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out       <= '0;
      epc_out      <= '0;
      vector_out   <= '0;
      exc_mem_addr <= '0;
      cause_q      <= EXC_NONE;
    end else begin
      if (take_exc) begin
        epc_out      <= pc_out - EPC_OFFSET;
        cause_q      <= enc_cause;
        exc_mem_addr <= enc_addr;
      end
      if (pc_en) begin
        pc_out <= pc_next;
      end
      if (capture) begin
        vector_out <= {24'b0, mem_rdata[7:0]};
      end
      if (load_vec) begin
        pc_out       <= vector_out;
        exc_mem_addr <= '0;
      end
    end
  end

endmodule : pc_exception_unit
`default_nettype wire

// File: tb/tb_pc_exception_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_exception_unit
// Description : Self-checking bench for pc_exception_unit. Two instances run
//               with memory latencies 1 and 3. Expected exception responses
//               are queued when the stimulus is issued and popped by a
//               monitor when a DUT raises exc_mem_req or leaves busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_exception_unit;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam logic [31:0] GARBAGE = 32'hDEADBE11;

  typedef struct {
    int          dut;
    logic [31:0] addr;
    logic [31:0] epc;
    logic [1:0]  cause;
  } req_t;

  typedef struct {
    int          dut;
    logic [31:0] pc;
    logic [31:0] vec;
    logic [31:0] epc;
    logic [1:0]  cause;
    int          busy;
  } done_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc_next       [2];
  logic        pc_write      [2];
  logic        pc_write_cond [2];
  logic        branch_cond   [2];
  logic        exc_opcode    [2];
  logic        exc_overflow  [2];
  logic        exc_div0      [2];
  logic [31:0] mem_rdata     [2];
  logic [31:0] pc_out        [2];
  logic [31:0] epc_out       [2];
  logic [31:0] vector_out    [2];
  logic [31:0] exc_mem_addr  [2];
  logic        exc_mem_req   [2];
  logic        exc_busy      [2];
  logic [1:0]  exc_cause     [2];

  logic [31:0] mem_val [2];

  req_t  req_q[$];
  done_t done_q[$];

  int errors = 0;
  int checks = 0;

  pc_exception_unit #(.MEM_LAT(LAT0)) dut0 (
    .clk(clk), .reset(reset),
    .pc_next(pc_next[0]), .pc_write(pc_write[0]),
    .pc_write_cond(pc_write_cond[0]), .branch_cond(branch_cond[0]),
    .exc_opcode(exc_opcode[0]), .exc_overflow(exc_overflow[0]),
    .exc_div0(exc_div0[0]), .mem_rdata(mem_rdata[0]),
    .pc_out(pc_out[0]), .epc_out(epc_out[0]), .vector_out(vector_out[0]),
    .exc_mem_addr(exc_mem_addr[0]), .exc_mem_req(exc_mem_req[0]),
    .exc_busy(exc_busy[0]), .exc_cause(exc_cause[0])
  );

  pc_exception_unit #(.MEM_LAT(LAT1)) dut1 (
    .clk(clk), .reset(reset),
    .pc_next(pc_next[1]), .pc_write(pc_write[1]),
    .pc_write_cond(pc_write_cond[1]), .branch_cond(branch_cond[1]),
    .exc_opcode(exc_opcode[1]), .exc_overflow(exc_overflow[1]),
    .exc_div0(exc_div0[1]), .mem_rdata(mem_rdata[1]),
    .pc_out(pc_out[1]), .epc_out(epc_out[1]), .vector_out(vector_out[1]),
    .exc_mem_addr(exc_mem_addr[1]), .exc_mem_req(exc_mem_req[1]),
    .exc_busy(exc_busy[1]), .exc_cause(exc_cause[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (exc_busy[d] !== 1'b0 && n < 32) begin
      tick();
      n++;
    end
    check($sformatf("idle_timeout[%0d]", d), {31'b0, exc_busy[d]}, 32'd0);
  endtask

  // Fixed-latency memory model: the vector word is valid only on the edge
  // MEM_LAT cycles after the edge that samples exc_mem_req; garbage otherwise.
  initial begin
    int mk [2];
    mk[0] = -1;
    mk[1] = -1;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (exc_mem_req[d] === 1'b1) mk[d] = (d == 0) ? LAT0 : LAT1;
        else if (mk[d] >= 0) mk[d] = mk[d] - 1;
        mem_rdata[d] = (mk[d] == 0) ? mem_val[d] : GARBAGE;
      end
    end
  end

  // Scoreboard monitor: checks request beats and completed entry sequences
  initial begin
    int   bcnt [2];
    logic prev [2];
    bcnt[0] = 0; bcnt[1] = 0;
    prev[0] = 1'b0; prev[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (exc_mem_req[d] === 1'b1) begin
          if (req_q.size() == 0 || req_q[0].dut != d) begin
            check($sformatf("unexpected_req[%0d]", d), 32'd1, 32'd0);
          end else begin
            req_t r;
            r = req_q.pop_front();
            check($sformatf("req_addr[%0d]", d), exc_mem_addr[d], r.addr);
            check($sformatf("req_epc[%0d]", d), epc_out[d], r.epc);
            check($sformatf("req_cause[%0d]", d), {30'b0, exc_cause[d]}, {30'b0, r.cause});
            check($sformatf("req_busy[%0d]", d), {31'b0, exc_busy[d]}, 32'd1);
          end
        end
        if (exc_busy[d] === 1'b1) begin
          bcnt[d]++;
        end else if (prev[d] === 1'b1) begin
          if (done_q.size() == 0 || done_q[0].dut != d) begin
            check($sformatf("unexpected_done[%0d]", d), 32'd1, 32'd0);
          end else begin
            done_t e;
            e = done_q.pop_front();
            check($sformatf("done_pc[%0d]", d), pc_out[d], e.pc);
            check($sformatf("done_vec[%0d]", d), vector_out[d], e.vec);
            check($sformatf("done_epc[%0d]", d), epc_out[d], e.epc);
            check($sformatf("done_cause[%0d]", d), {30'b0, exc_cause[d]}, {30'b0, e.cause});
            check($sformatf("busy_len[%0d]", d), bcnt[d], e.busy);
          end
          bcnt[d] = 0;
        end
        prev[d] = exc_busy[d];
      end
    end
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      pc_next[d] = '0; pc_write[d] = 1'b0; pc_write_cond[d] = 1'b0;
      branch_cond[d] = 1'b0; exc_opcode[d] = 1'b0; exc_overflow[d] = 1'b0;
      exc_div0[d] = 1'b0; mem_val[d] = '0;
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset state of both instances
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_pc[%0d]", d), pc_out[d], 32'd0);
      check($sformatf("rst_epc[%0d]", d), epc_out[d], 32'd0);
      check($sformatf("rst_vec[%0d]", d), vector_out[d], 32'd0);
      check($sformatf("rst_addr[%0d]", d), exc_mem_addr[d], 32'd0);
      check($sformatf("rst_cause[%0d]", d), {30'b0, exc_cause[d]}, 32'd0);
      check($sformatf("rst_req[%0d]", d), {31'b0, exc_mem_req[d]}, 32'd0);
      check($sformatf("rst_busy[%0d]", d), {31'b0, exc_busy[d]}, 32'd0);
    end

    // Basic unconditional write
    pc_next[0] = 32'h4; pc_write[0] = 1'b1;
    tick();
    pc_write[0] = 1'b0;
    check("write_pc", pc_out[0], 32'h4);
    check("write_epc", epc_out[0], 32'h0);
    check("write_busy", {31'b0, exc_busy[0]}, 32'd0);

    // Conditional write: blocked, then taken
    pc_next[0] = 32'h40; pc_write_cond[0] = 1'b1; branch_cond[0] = 1'b0;
    tick();
    check("cond_hold_pc", pc_out[0], 32'h4);
    branch_cond[0] = 1'b1;
    tick();
    pc_write_cond[0] = 1'b0; branch_cond[0] = 1'b0;
    check("cond_take_pc", pc_out[0], 32'h40);

    // Overflow entry with latency 1
    pc_next[0] = 32'h18; pc_write[0] = 1'b1;
    tick();
    pc_write[0] = 1'b0;
    check("pc_0x18", pc_out[0], 32'h18);
    mem_val[0] = 32'h12345690;
    req_q.push_back('{dut: 0, addr: 32'd254, epc: 32'h14, cause: 2'd2});
    done_q.push_back('{dut: 0, pc: 32'h90, vec: 32'h90, epc: 32'h14, cause: 2'd2, busy: 3});
    exc_overflow[0] = 1'b1;
    tick();
    exc_overflow[0] = 1'b0;
    check("ovf_busy", {31'b0, exc_busy[0]}, 32'd1);
    wait_idle(0);

    // Simultaneous opcode+div0 with a PC write; nested div0 and writes while busy
    mem_val[0] = 32'hFFFFFF3C;
    req_q.push_back('{dut: 0, addr: 32'd253, epc: 32'h8C, cause: 2'd1});
    done_q.push_back('{dut: 0, pc: 32'h3C, vec: 32'h3C, epc: 32'h8C, cause: 2'd1, busy: 3});
    exc_opcode[0] = 1'b1; exc_div0[0] = 1'b1; pc_write[0] = 1'b1; pc_next[0] = 32'h1000;
    tick();
    exc_opcode[0] = 1'b0;
    check("simul_no_write", pc_out[0], 32'h90);
    pc_write_cond[0] = 1'b1; branch_cond[0] = 1'b1;
    repeat (2) tick();
    exc_div0[0] = 1'b0; pc_write[0] = 1'b0; pc_write_cond[0] = 1'b0; branch_cond[0] = 1'b0;
    wait_idle(0);
    check("simul_addr_clear", exc_mem_addr[0], 32'h0);

    // EPC wrap and latency 3
    mem_val[1] = 32'h550000A7;
    req_q.push_back('{dut: 1, addr: 32'd255, epc: 32'hFFFFFFFC, cause: 2'd3});
    done_q.push_back('{dut: 1, pc: 32'hA7, vec: 32'hA7, epc: 32'hFFFFFFFC, cause: 2'd3, busy: 5});
    exc_div0[1] = 1'b1;
    tick();
    exc_div0[1] = 1'b0;
    repeat (3) tick();
    check("vec_before_capture", vector_out[1], 32'h0);
    tick();
    check("vec_at_capture", vector_out[1], 32'hA7);
    wait_idle(1);

    // Reset during WAIT aborts the entry without a PC load
    req_q.push_back('{dut: 1, addr: 32'd254, epc: 32'hA3, cause: 2'd2});
    done_q.push_back('{dut: 1, pc: 32'h0, vec: 32'h0, epc: 32'h0, cause: 2'd0, busy: 2});
    mem_val[1] = 32'h000000EE;
    exc_overflow[1] = 1'b1;
    tick();
    exc_overflow[1] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_pc", pc_out[1], 32'h0);
    check("mid_rst_epc", epc_out[1], 32'h0);
    check("mid_rst_vec", vector_out[1], 32'h0);
    check("mid_rst_addr", exc_mem_addr[1], 32'h0);
    check("mid_rst_cause", {30'b0, exc_cause[1]}, 32'd0);
    check("mid_rst_busy", {31'b0, exc_busy[1]}, 32'd0);
    repeat (6) tick();
    check("mid_rst_no_load", pc_out[1], 32'h0);
    check("mid_rst_no_vec", vector_out[1], 32'h0);

    tick();
    check("req_q_empty", req_q.size(), 32'd0);
    check("done_q_empty", done_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_exception_unit
`default_nettype wire
